// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
//  Module      : cond_logic
//  Description : Conditional-execution unit for the multicycle ARM core.
//                Holds the NZCV flag register, evaluates the instruction
//                condition field against it, and gates the FSM's PC,
//                register-file and memory write strobes with the registered
//                condition result.
//  Ports       : clk       - system clock, rising-edge active
//                reset     - synchronous active-high reset (clears flags and
//                            the registered condition result)
//                Cond      - instruction condition field Instr[31:28]
//                ALUFlags  - {N,Z,C,V} from the ALU this cycle
//                FlagW     - flag write request [1]=N,Z group [0]=C,V group
//                PCS       - instruction writes the PC
//                NextPC    - unconditional PC update from the FSM (Fetch)
//                RegW      - register write request from the FSM
//                MemW      - memory write request from the FSM
//                NoWrite   - suppress register write (compare/test ops)
//                PCWrite   - PC register enable
//                RegWrite  - register file write enable
//                MemWrite  - data memory write enable
//                Flags     - current {N,Z,C,V} register contents
//                CondEx    - combinational condition result
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    // Condition field encodings
    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_CS = 4'b0010;
    localparam logic [3:0] C_CC = 4'b0011;
    localparam logic [3:0] C_MI = 4'b0100;
    localparam logic [3:0] C_PL = 4'b0101;
    localparam logic [3:0] C_VS = 4'b0110;
    localparam logic [3:0] C_VC = 4'b0111;
    localparam logic [3:0] C_HI = 4'b1000;
    localparam logic [3:0] C_LS = 4'b1001;
    localparam logic [3:0] C_GE = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_GT = 4'b1100;
    localparam logic [3:0] C_LE = 4'b1101;

    logic [3:0] r_flags_q;
    logic [3:0] w_flags_d;
    logic       r_cond_ex_q;
    logic       w_cond_ex_d;
    logic [1:0] w_flag_write;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_n = r_flags_q[3];
    assign w_z = r_flags_q[2];
    assign w_c = r_flags_q[1];
    assign w_v = r_flags_q[0];

    // Condition is evaluated against the registered flags only, so an
    // instruction that sets flags is judged by the flags that preceded it.
    always_comb begin
        w_cond_ex_d = 1'b1;
        case (Cond)
            C_EQ:    w_cond_ex_d = w_z;
            C_NE:    w_cond_ex_d = ~w_z;
            C_CS:    w_cond_ex_d = w_c;
            C_CC:    w_cond_ex_d = ~w_c;
            C_MI:    w_cond_ex_d = w_n;
            C_PL:    w_cond_ex_d = ~w_n;
            C_VS:    w_cond_ex_d = w_v;
            C_VC:    w_cond_ex_d = ~w_v;
            C_HI:    w_cond_ex_d = w_c & ~w_z;
            C_LS:    w_cond_ex_d = ~w_c | w_z;
            C_GE:    w_cond_ex_d = (w_n == w_v);
            C_LT:    w_cond_ex_d = (w_n != w_v);
            C_GT:    w_cond_ex_d = ~w_z & (w_n == w_v);
            C_LE:    w_cond_ex_d = w_z | (w_n != w_v);
            default: w_cond_ex_d = 1'b1; // AL, and 1111 behaves as AL
        endcase
    end

    // N,Z and C,V are independently writable groups.
    always_comb begin
        w_flag_write = FlagW & {2{w_cond_ex_d}};
        w_flags_d    = r_flags_q;
        if (w_flag_write[1]) begin
            w_flags_d[3:2] = ALUFlags[3:2];
        end
        if (w_flag_write[0]) begin
            w_flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags_q   <= 4'b0000;
            r_cond_ex_q <= 1'b0;
        end else begin
            r_flags_q   <= w_flags_d;
            r_cond_ex_q <= w_cond_ex_d;
        end
    end

    // Gated strobes use last cycle's condition result; the FSM keeps Cond
    // stable from Decode through writeback so this matches the current
    // instruction. Reset also masks the strobes combinationally so nothing
    // is written while reset is held. NextPC is never gated.
    assign PCWrite  = (PCS & r_cond_ex_q & ~reset) | NextPC;
    assign RegWrite = RegW & r_cond_ex_q & ~NoWrite & ~reset;
    assign MemWrite = MemW & r_cond_ex_q & ~reset;
    assign Flags    = r_flags_q;
    assign CondEx   = w_cond_ex_d;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_logic
//  Description : Self-checking scoreboard bench for cond_logic. Each directed
//                step drives one cycle of inputs and queues the hand-derived
//                expected outputs; a monitor on the falling edge pops and
//                compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    cond_logic u_dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    // Falling edge at 5, rising edge at 10: inputs driven just after a
    // rising edge are sampled at the next falling edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp; // {Flags, CondEx, PCWrite, RegWrite, MemWrite}
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string n, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, req);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp({e.name, ".Flags"},    Flags,            e.exp[7:4]);
            cmp({e.name, ".CondEx"},   {3'b0, CondEx},   {3'b0, e.exp[3]});
            cmp({e.name, ".PCWrite"},  {3'b0, PCWrite},  {3'b0, e.exp[2]});
            cmp({e.name, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, e.exp[1]});
            cmp({e.name, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, e.exp[0]});
        end
    end

    // ctl = {PCS, NextPC, RegW, MemW, NoWrite}
    // exp = {Flags[3:0], CondEx, PCWrite, RegWrite, MemWrite}
    task automatic step(input string name, input bit chk, input logic rst,
                        input logic [3:0] cond, input logic [3:0] alu,
                        input logic [1:0] fw, input logic [4:0] ctl,
                        input logic [7:0] exp);
        exp_t e;
        reset    = rst;
        Cond     = cond;
        ALUFlags = alu;
        FlagW    = fw;
        {PCS, NextPC, RegW, MemW, NoWrite} = ctl;
        if (chk) begin
            e.name = name;
            e.exp  = exp;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //    name          chk rst cond     alu      fw     ctl       {F,cex,pcw,rw,mw}
        step("rst0",        0, 1, 4'b1110, 4'b0000, 2'b00, 5'b00000, 8'b0000_0000);
        step("rst_hold",    1, 1, 4'b1110, 4'b0000, 2'b00, 5'b11110, 8'b0000_1100);
        step("al_first",    1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00100, 8'b0000_1000);
        step("al_second",   1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00100, 8'b0000_1010);
        step("set_z",       1, 0, 4'b1110, 4'b0100, 2'b11, 5'b00000, 8'b0000_1000);
        step("ne_prev_ok",  1, 0, 4'b0001, 4'b0000, 2'b00, 5'b10110, 8'b0100_0111);
        step("ne_gated",    1, 0, 4'b0001, 4'b0000, 2'b00, 5'b10110, 8'b0100_0000);
        step("eq_cv_wr",    1, 0, 4'b0000, 4'b0011, 2'b01, 5'b00000, 8'b0100_1000);
        step("eq_nz_wr",    1, 0, 4'b0000, 4'b1000, 2'b10, 5'b00000, 8'b0111_1000);
        step("flags_1011",  1, 0, 4'b0000, 4'b0000, 2'b00, 5'b00000, 8'b1011_0000);
        step("cv_only",     1, 0, 4'b1110, 4'b0100, 2'b01, 5'b00000, 8'b1011_1000);
        step("ge",          1, 0, 4'b1010, 4'b0000, 2'b00, 5'b00000, 8'b1000_0000);
        step("lt",          1, 0, 4'b1011, 4'b0000, 2'b00, 5'b00000, 8'b1000_1000);
        step("gt",          1, 0, 4'b1100, 4'b0000, 2'b00, 5'b00000, 8'b1000_0000);
        step("le",          1, 0, 4'b1101, 4'b0000, 2'b00, 5'b00000, 8'b1000_1000);
        step("hi",          1, 0, 4'b1000, 4'b0000, 2'b00, 5'b00000, 8'b1000_0000);
        step("mi",          1, 0, 4'b0100, 4'b0000, 2'b00, 5'b00000, 8'b1000_1000);
        step("nv_as_al",    1, 0, 4'b1111, 4'b0000, 2'b00, 5'b00000, 8'b1000_1000);
        step("set_z2",      1, 0, 4'b1110, 4'b0100, 2'b11, 5'b00000, 8'b1000_1000);
        step("blocked_fw",  1, 0, 4'b0001, 4'b1111, 2'b11, 5'b01000, 8'b0100_0100);
        step("nextpc_ungt", 1, 0, 4'b0001, 4'b1111, 2'b11, 5'b11100, 8'b0100_0100);
        step("nowrite_a",   1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00101, 8'b0100_1000);
        step("nowrite_b",   1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00111, 8'b0100_1001);
        step("set_all",     1, 0, 4'b1110, 4'b1111, 2'b11, 5'b00100, 8'b0100_1010);
        step("mid_reset",   1, 1, 4'b1110, 4'b0000, 2'b00, 5'b00110, 8'b1111_1000);
        step("post_rst1",   1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00100, 8'b0000_1000);
        step("post_rst2",   1, 0, 4'b1110, 4'b0000, 2'b00, 5'b00000, 8'b0000_1000);
        step("cs",          1, 0, 4'b0010, 4'b0000, 2'b00, 5'b00100, 8'b0000_0010);
        step("cc",          1, 0, 4'b0011, 4'b0000, 2'b00, 5'b00100, 8'b0000_1000);
        step("vs",          1, 0, 4'b0110, 4'b0000, 2'b00, 5'b00000, 8'b0000_0000);
        step("pl",          1, 0, 4'b0101, 4'b0000, 2'b00, 5'b00000, 8'b0000_1000);
        step("vc",          1, 0, 4'b0111, 4'b0000, 2'b00, 5'b00000, 8'b0000_1000);
        step("ls",          1, 0, 4'b1001, 4'b0000, 2'b00, 5'b00000, 8'b0000_1000);

        // Give the monitor a bounded window to drain the scoreboard.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the multicycle ARM core. It holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against it. It registers the result so it stays valid across the execute and writeback states. It also gates the main FSM's PC, register-file and memory write strobes. It sits between the main control FSM, the ALU flag outputs and the datapath write enables.

## Interface
Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears Flags and CondExReg
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- FlagW  in  2  flag write request from decoder; [1] = N,Z group, [0] = C,V group
- PCS  in  1  instruction writes PC (branch or Rd=R15), from decoder
- NextPC  in  1  unconditional PC update request from FSM (Fetch state)
- RegW  in  1  register write request from FSM
- MemW  in  1  memory write request from FSM
- NoWrite  in  1  suppress register write (CMP/CMN/TST/TEQ)
- PCWrite  out  1  PC register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- Flags  out  4  current {N,Z,C,V} register contents
- CondEx  out  1  combinational condition result (debug/visibility)

## Operation
- Flag register: Flags[3:2] (N,Z) and Flags[1:0] (C,V) are two independent 2-bit registers.
- FlagWrite[1] = FlagW[1] & CondEx loads Flags[3:2] <= ALUFlags[3:2].
- FlagWrite[0] = FlagW[0] & CondEx loads Flags[1:0] <= ALUFlags[1:0].
- CondEx is combinational from Cond and the *registered* Flags. Never use ALUFlags for it.
- Condition table (N,Z,C,V = Flags[3..0]):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as AL (1)
- CondExReg <= CondEx every cycle (no enable).
- Output gating:
  - PCWrite = (PCS & CondExReg) | NextPC
  - RegWrite = RegW & CondExReg & !NoWrite
  - MemWrite = MemW & CondExReg
- NextPC is never gated, so Fetch always advances the PC.

## Timing
- Reset (synchronous): Flags = 4'b0000, CondExReg = 0.
- While reset is high and after reset: RegWrite = MemWrite = 0, and PCWrite = NextPC.
- CondEx: zero-latency, combinational from Cond and Flags.
- Gated write strobes use CondExReg, i.e. CondEx from the previous cycle. The FSM holds Cond stable from Decode through writeback, so the gating is consistent.
- A flag update at edge k is visible in Flags and CondEx in cycle k+1. An instruction setting flags evaluates its own condition with the old flags.
- Simultaneous FlagW with CondEx = 0: no flag change.
- FlagW = 2'b10: only N,Z change; C,V hold, even if ALUFlags[1:0] differ.
- Reset asserted mid-instruction: flags clear at that edge. Writes are suppressed from the following cycle (CondExReg = 0) until a condition passes again.
- All outputs are glitch-tolerant combinational functions of registered state and FSM inputs. There is no internal FSM.

## Test plan
- Reset, then Cond=1110 and RegW=1 for 2 cycles -> Flags=0000, CondEx=1, RegWrite=0 in the first cycle after reset and 1 from the second cycle.
- Cond=1110, FlagW=11, ALUFlags=0100, one edge, then Cond=0001 (NE) -> Flags=0100, CondEx=0; with RegW=MemW=PCS=1 one cycle later, RegWrite=MemWrite=PCWrite=0.
- Flags=0100, Cond=0000 (EQ), FlagW=01, ALUFlags=0011 -> after edge Flags=0111. Then FlagW=10, ALUFlags=1000 -> Flags=1011.
- Flags=1000 (N=1, V=0), sweep Cond through GE/LT/GT/LE -> CondEx = 0, 1, 0, 1 respectively.
- Cond=0001 with Z=1, FlagW=11, ALUFlags=1111 -> Flags unchanged; NextPC=1 -> PCWrite=1 regardless.
- Cond=1110, RegW=1, NoWrite=1 -> RegWrite=0. Assert reset for one edge with Flags=1111 -> Flags=0000 and RegWrite=0 in the next cycle.
